dc_mseq: RTL and testbench
==========================

# dc_mseq

Parametrised synchronous microsequencer for the F11 control-chip set. It generalises the single-chip next-address logic to CHIPS microcode sections selected one-hot. It adds a CALL/RET return stack and prioritised interrupt vectoring at the read-next-instruction (RNI) point. It drives an external asynchronous microcode store (PLA/ROM/LUT) and issues one registered microword per clock to the data path.

## Interface
- AW, 9: microaddress width (≥8)
- MW, 16: microword width (≥16; opcode field is mi[15:11])
- CHIPS, 3: number of microcode sections (1..8)
- SDEPTH, 4: return-stack depth (≥1)
- IRQN, 4: interrupt request lines (1..7)
- VEC_BASE, 9'o020: microaddress of IRQ line 0 service entry in section 0; line i enters at VEC_BASE+i

- pin_clk  in  1  single clock, all state on rising edge
- pin_rst_n  in  1  reset, synchronous, active-low
- pin_ma  out  AW  microaddress to store (registered)
- pin_cs  out  CHIPS  one-hot section select to store (registered)
- pin_rd  in  AW+MW  store read data {na_field, mi}, valid combinationally while pin_ma/pin_cs stable
- pin_m  out  MW  issued microword (registered)
- pin_mv  out  1  pin_m valid this cycle
- pin_stall  in  1  hold sequencer
- pin_cond  in  1  condition for CJMP
- pin_ad  in  16  data bus; pin_ad[7:5] loaded as priority by LDPRI
- pin_irq  in  IRQN  level requests; line i has priority level i+4 (capped at 7)
- pin_ack  out  IRQN  one-cycle acknowledge of vectored line
- pin_pri  out  3  current priority register
- pin_flags  out  3  sticky {cserr, sund, sovf}

## Operation
- Reset (pin_rst_n=0 at edge): pin_ma=0, pin_cs=1 (section 0), pin_m=0, pin_mv=0, pin_ack=0, pin_pri=7, pin_flags=0, stack empty. Reset overrides stall and everything else.
- Each non-stalled cycle: pin_m<=pin_rd mi part, pin_mv<=1, then next address/section loaded per opcode op=mi[15:11] of pin_rd:
  - 00000 JMP: section <= mi[10:6]; na = {0…, mi[5:0]}.
  - 00001 CJMP: if pin_cond=1, na = {na_field[AW-1:8], mi[7:0]}; else na_field.
  - 00010 CALL: push {section, na_field}; na = mi[AW-1:0] in same section.
  - 00011 RET: pop {section, address} into next.
  - 00100 LDPRI: pin_pri <= pin_ad[7:5]; na = na_field.
  - 00101 CLRF: pin_flags <= 0; na = na_field.
  - other: na = na_field, section unchanged.
- JMP section number ≥ CHIPS: set cserr; next = section 0, address 0.
- CALL with stack full: set sovf, no push, jump still taken. RET with stack empty: set sund, next = section 0, address 0.
- RNI: computed next address is 0 in section 0 (incl. error redirects). Then take the highest i with pin_irq[i]=1 and level(i) > pin_pri. If one exists, next = section 0, VEC_BASE+i, and pin_ack[i]=1 for exactly that cycle. Otherwise next stays at 0.
- Stack is LIFO of SDEPTH entries of (log2 CHIPS + AW) bits; a depth counter 0..SDEPTH gives full/empty.

## Timing
- Zero-bubble branches: next address comes from the current pin_rd in the same cycle, so one microword issues per clock.
- pin_m lags pin_ma/pin_cs by one cycle. pin_rd must settle within the cycle.
- pin_cond, pin_irq and pin_ad are sampled at the edge ending the cycle in which the deciding word is on pin_rd.
- pin_stall=1: pin_ma, pin_cs, pin_m, stack, pri and flags hold; pin_mv=0; pin_ack=0. No IRQ is vectored during stall.
- LDPRI and RNI in the same word: the mask uses the old pin_pri.
- Reset mid-CALL/RET: stack cleared; the push/pop is discarded.

## Test plan
- Reset release with pin_rd word at 0 = {na=5, op=10000}: pin_ma 0→5, pin_mv=1 one cycle after release, pin_pri=7.
- CJMP mi[7:0]=8'h40, na_field=9'h1A3: pin_cond=1 → pin_ma=9'h140; pin_cond=0 → 9'h1A3.
- JMP mi[10:6]=2: pin_cs=3'b100, pin_ma=mi[5:0]. JMP mi[10:6]=5 with CHIPS=3: cserr=1, pin_cs=1, pin_ma=0.
- Five nested CALLs with SDEPTH=4: sovf=1 after the fifth; four RETs return in LIFO order; fifth RET sets sund, pin_ma=0.
- pin_pri=5, pin_irq=4'b1011 at RNI: line 3 (level 7) wins, pin_ma=VEC_BASE+3, pin_ack=4'b1000 for one cycle. With pin_pri=7, no vector and pin_ma=0.
- pin_stall held 3 cycles mid-stream: pin_ma/pin_m frozen, pin_mv=0, sequence resumes unchanged afterwards.

Source files
------------

// File: rtl/dc_mseq.sv
// dc_mseq: multi-section microsequencer driving an asynchronous microcode store.
// It issues one microword per clock and supports a CALL/RET stack and IRQ vectoring at RNI.
module dc_mseq #(
  parameter int           AW       = 9,
  parameter int           MW       = 16,
  parameter int           CHIPS    = 3,
  parameter int           SDEPTH   = 4,
  parameter int           IRQN     = 4,
  parameter logic [AW-1:0] VEC_BASE = 9'o020
) (
  input  logic              pin_clk,
  input  logic              pin_rst_n,
  output logic [AW-1:0]     pin_ma,
  output logic [CHIPS-1:0]  pin_cs,
  input  logic [AW+MW-1:0]  pin_rd,
  output logic [MW-1:0]     pin_m,
  output logic              pin_mv,
  input  logic              pin_stall,
  input  logic              pin_cond,
  input  logic [15:0]       pin_ad,
  input  logic [IRQN-1:0]   pin_irq,
  output logic [IRQN-1:0]   pin_ack,
  output logic [2:0]        pin_pri,
  output logic [2:0]        pin_flags
);

  localparam int SW = (CHIPS > 1) ? $clog2(CHIPS) : 1;
  localparam int DW = $clog2(SDEPTH + 1);
  localparam int IW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  typedef enum logic [4:0] {
    OP_JMP   = 5'd0,
    OP_CJMP  = 5'd1,
    OP_CALL  = 5'd2,
    OP_RET   = 5'd3,
    OP_LDPRI = 5'd4,
    OP_CLRF  = 5'd5
  } op_e;

  logic [AW-1:0]    ma_q, ma_d;
  logic [SW-1:0]    sec_q, sec_d;
  logic [CHIPS-1:0] cs_q, cs_d;
  logic [MW-1:0]    m_q;
  logic             mv_q;
  logic [IRQN-1:0]  ack_q, ack_d;
  logic [2:0]       pri_q, pri_d;
  logic [2:0]       flags_q, flags_d;   // {cserr, sund, sovf}
  logic [DW-1:0]    dep_q, dep_d;
  logic [SW+AW-1:0] stk_q [SDEPTH];

  logic [AW-1:0]    na_field;
  logic [MW-1:0]    mi;
  op_e              op;
  logic             push;
  logic [IW-1:0]    top_idx;
  logic [2:0]       lvl;

  assign na_field = pin_rd[AW+MW-1:MW];
  assign mi       = pin_rd[MW-1:0];
  assign op       = op_e'(mi[15:11]);
  assign top_idx  = IW'(dep_q - DW'(1));

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    ma_d    = na_field;
    sec_d   = sec_q;
    pri_d   = pri_q;
    flags_d = flags_q;
    dep_d   = dep_q;
    push    = 1'b0;
    ack_d   = '0;
    lvl     = 3'd0;
    unique case (op)
      OP_JMP: begin
        if (mi[10:6] < 5'(CHIPS)) begin
          sec_d = mi[6 +: SW];
          ma_d  = AW'(mi[5:0]);
        end else begin
          flags_d[2] = 1'b1;
          sec_d      = '0;
          ma_d       = '0;
        end
      end
      OP_CJMP: if (pin_cond) ma_d = (na_field & ~AW'(8'hFF)) | AW'(mi[7:0]);
      OP_CALL: begin
        ma_d = mi[AW-1:0];
        if (dep_q == DW'(SDEPTH)) begin
          flags_d[0] = 1'b1;
        end else begin
          push  = 1'b1;
          dep_d = dep_q + DW'(1);
        end
      end
      OP_RET: begin
        if (dep_q == '0) begin
          flags_d[1] = 1'b1;
          sec_d      = '0;
          ma_d       = '0;
        end else begin
          {sec_d, ma_d} = stk_q[top_idx];
          dep_d         = dep_q - DW'(1);
        end
      end
      OP_LDPRI: pri_d = pin_ad[7:5];
      OP_CLRF:  flags_d = '0;
      default:  ;
    endcase
    // RNI: ascending scan so the highest eligible line is the last to win; masked by the old priority.
    if (sec_d == '0 && ma_d == '0) begin
      for (int i = 0; i < IRQN; i++) begin
        lvl = (i + 4 > 7) ? 3'd7 : 3'(i + 4);
        if (pin_irq[i] && lvl > pri_q) begin
          ack_d    = '0;
          ack_d[i] = 1'b1;
          ma_d     = VEC_BASE + AW'(i);
        end
      end
    end
    cs_d = CHIPS'(1) << sec_d;
  end

  always_ff @(posedge pin_clk) begin
    if (!pin_rst_n) begin
      ma_q    <= '0;
      sec_q   <= '0;
      cs_q    <= CHIPS'(1);
      m_q     <= '0;
      mv_q    <= 1'b0;
      ack_q   <= '0;
      pri_q   <= 3'd7;
      flags_q <= '0;
      dep_q   <= '0;
    end else if (pin_stall) begin
      mv_q  <= 1'b0;
      ack_q <= '0;
    end else begin
      ma_q    <= ma_d;
      sec_q   <= sec_d;
      cs_q    <= cs_d;
      m_q     <= mi;
      mv_q    <= 1'b1;
      ack_q   <= ack_d;
      pri_q   <= pri_d;
      flags_q <= flags_d;
      dep_q   <= dep_d;
    end
  end

  // NOTE: stack storage has no reset; clearing the depth counter is enough to empty it.
  always_ff @(posedge pin_clk) begin
    if (pin_rst_n && !pin_stall && push) stk_q[dep_q[IW-1:0]] <= {sec_q, na_field};
  end

  logic unused_ok;
  assign unused_ok = ^{pin_ad[15:8], pin_ad[4:0]};

  assign pin_ma    = ma_q;
  assign pin_cs    = cs_q;
  assign pin_m     = m_q;
  assign pin_mv    = mv_q;
  assign pin_ack   = ack_q;
  assign pin_pri   = pri_q;
  assign pin_flags = flags_q;

endmodule

// File: tb/tb_dc_mseq.sv
// tb_dc_mseq: directed bench for dc_mseq; the bench drives pin_rd directly as the store.
module tb_dc_mseq;
  localparam int AW = 9, MW = 16, CHIPS = 3, SDEPTH = 4, IRQN = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     ma;
  logic [CHIPS-1:0]  cs;
  logic [AW+MW-1:0]  rd;
  logic [MW-1:0]     m;
  logic              mv;
  logic              stall;
  logic              cond;
  logic [15:0]       ad;
  logic [IRQN-1:0]   irq;
  logic [IRQN-1:0]   ack;
  logic [2:0]        pri;
  logic [2:0]        flags;

  int total = 0;
  int bad   = 0;

  dc_mseq #(.AW(AW), .MW(MW), .CHIPS(CHIPS), .SDEPTH(SDEPTH), .IRQN(IRQN), .VEC_BASE(9'o020)) dut (
    .pin_clk(clk), .pin_rst_n(rst_n), .pin_ma(ma), .pin_cs(cs), .pin_rd(rd),
    .pin_m(m), .pin_mv(mv), .pin_stall(stall), .pin_cond(cond), .pin_ad(ad),
    .pin_irq(irq), .pin_ack(ack), .pin_pri(pri), .pin_flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW+MW-1:0] w(input logic [8:0] na, input logic [4:0] op, input logic [10:0] lo);
    return {na, op, lo};
  endfunction

  // Present a store word, let one rising edge consume it, sample 1 time unit later.
  task automatic cyc(input logic [AW+MW-1:0] word);
    rd = word;
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] NOP = 5'b10000;

  initial begin
    rst_n = 1'b0; stall = 1'b0; cond = 1'b0; ad = '0; irq = '0;
    rd = w(9'd5, NOP, 11'd0);
    cyc(w(9'd5, NOP, 11'd0));
    cyc(w(9'd5, NOP, 11'd0));
    check("rst_ma", ma, 0);
    check("rst_cs", cs, 3'b001);
    check("rst_m", m, 0);
    check("rst_mv", mv, 0);
    check("rst_ack", ack, 0);
    check("rst_pri", pri, 7);
    check("rst_flags", flags, 0);

    rst_n = 1'b1;
    cyc(w(9'd5, NOP, 11'd0));
    check("rel_ma", ma, 5);
    check("rel_mv", mv, 1);
    check("rel_m", m, 16'h8000);
    check("rel_pri", pri, 7);

    cond = 1'b1;
    cyc(w(9'h1A3, 5'd1, 11'h040));
    check("cjmp_t", ma, 9'h140);
    cond = 1'b0;
    cyc(w(9'h1A3, 5'd1, 11'h040));
    check("cjmp_f", ma, 9'h1A3);
    check("cjmp_m", m, 16'h0840);

    cyc(w(9'h0, 5'd0, 11'h095));
    check("jmp_cs", cs, 3'b100);
    check("jmp_ma", ma, 9'h015);
    cyc(w(9'h0, 5'd0, 11'h147));
    check("cserr_flags", flags, 3'b100);
    check("cserr_cs", cs, 3'b001);
    check("cserr_ma", ma, 0);
    cyc(w(9'h033, 5'd5, 11'd0));
    check("clrf_flags", flags, 0);
    check("clrf_ma", ma, 9'h033);

    cyc(w(9'h0, 5'd0, 11'h060));
    check("jmp1_cs", cs, 3'b010);
    check("jmp1_ma", ma, 9'h020);
    for (int k = 1; k <= 5; k++) begin
      cyc(w(9'(9'h010 + k), 5'd2, 11'(11'h100 + k)));
      check("call_ma", ma, 9'h100 + k);
      check("call_cs", cs, 3'b010);
      check("call_flags", flags, (k == 5) ? 3'b001 : 3'b000);
    end
    for (int k = 4; k >= 1; k--) begin
      cyc(w(9'h0, 5'd3, 11'd0));
      check("ret_ma", ma, 9'h010 + k);
      check("ret_cs", cs, 3'b010);
    end
    cyc(w(9'h0, 5'd3, 11'd0));
    check("sund_flags", flags, 3'b011);
    check("sund_ma", ma, 0);
    check("sund_cs", cs, 3'b001);

    cyc(w(9'h03C, 5'd5, 11'd0));
    ad = 16'h00A0;
    cyc(w(9'h040, 5'd4, 11'd0));
    check("ldpri_pri", pri, 5);
    check("ldpri_ma", ma, 9'h040);

    irq = 4'b1011;
    cyc(w(9'h0, NOP, 11'd0));
    check("vec_ma", ma, 9'o020 + 3);
    check("vec_ack", ack, 4'b1000);
    cyc(w(9'h050, NOP, 11'd0));
    check("vec_ack_off", ack, 0);
    check("vec_next", ma, 9'h050);

    ad = 16'h00E0;
    irq = 4'b1000;
    cyc(w(9'h0, 5'd4, 11'd0));
    check("ldrni_ma", ma, 9'o020 + 3);
    check("ldrni_ack", ack, 4'b1000);
    check("ldrni_pri", pri, 7);
    irq = 4'b1111;
    cyc(w(9'h0, NOP, 11'd0));
    check("mask_ma", ma, 0);
    check("mask_ack", ack, 0);

    irq = 4'b0000;
    cyc(w(9'h060, NOP, 11'h011));
    check("pre_stall_ma", ma, 9'h060);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(w(9'h070, NOP, 11'h022));
      check("stall_ma", ma, 9'h060);
      check("stall_m", m, 16'h8011);
      check("stall_mv", mv, 0);
    end
    stall = 1'b0;
    cyc(w(9'h070, NOP, 11'h022));
    check("resume_ma", ma, 9'h070);
    check("resume_m", m, 16'h8022);
    check("resume_mv", mv, 1);

    cyc(w(9'h080, 5'd2, 11'h0F0));
    check("rcall_ma", ma, 9'h0F0);
    rst_n = 1'b0;
    cyc(w(9'h081, 5'd2, 11'h0F1));
    check("mid_rst_ma", ma, 0);
    check("mid_rst_mv", mv, 0);
    rst_n = 1'b1;
    cyc(w(9'h0, 5'd3, 11'd0));
    check("mid_rst_sund", flags, 3'b010);
    check("mid_rst_ret_ma", ma, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
